// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event classifier.
// Holds the FSM state encoding and the ms-to-cycles conversion used for timing windows.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS1      = 3'd1,
        ST_WAIT_SECOND = 3'd2,
        ST_PRESS2      = 3'd3,
        ST_LONG_HELD   = 3'd4
    } state_t;

    // Clamped to 1 so a tiny clock or window never yields a zero-length timer.
    function automatic int ms_to_cycles(input int freq, input int ms);
        int cyc;
        cyc = (freq / 1000) * ms;
        if (cyc < 1) begin
            cyc = 1;
        end
        return cyc;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector on the debounced button level.
// btn_prev resets high so a button already held at reset does not count as a press.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_prev_q;
    logic btn_prev_d;

    always_comb begin
        btn_prev_d = btn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q <= 1'b1;
        end else begin
            btn_prev_q <= btn_prev_d;
        end
    end

    assign rise = btn & ~btn_prev_q;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies a debounced button into short press, long press and double click events.
//
// state          | meaning
// ST_IDLE        | waiting for a fresh press edge
// ST_PRESS1      | first press held, counting towards the long-press threshold
// ST_WAIT_SECOND | first press released, counting the double-click window
// ST_PRESS2      | second press of a double click, waiting for release
// ST_LONG_HELD   | long press reported, btn_held high until release
module button_event_classifier
    import btn_evt_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_debounce,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic btn_held
);

    localparam int LONG_CYC   = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int DCLICK_CYC = ms_to_cycles(CLK_FREQ, DCLICK_MS);
    localparam int MAX_CYC    = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
    localparam int CNT_W      = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_press_q, short_press_d;
    logic             long_press_q, long_press_d;
    logic             double_click_q, double_click_d;
    logic             btn_held_q, btn_held_d;
    logic             rise;

    btn_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_debounce),
        .rise  (rise)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        double_click_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    cnt_d   = '0;
                end
            end
            ST_PRESS1: begin
                if (btn_debounce) begin
                    if (cnt_q == LONG_LAST) begin
                        long_press_d = 1'b1;
                        state_d      = ST_LONG_HELD;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_WAIT_SECOND;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_SECOND: begin
                // A second press wins over a timeout landing on the same edge.
                if (btn_debounce) begin
                    double_click_d = 1'b1;
                    state_d        = ST_PRESS2;
                    cnt_d          = '0;
                end else if (cnt_q == DCLICK_LAST) begin
                    short_press_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (!btn_debounce) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LONG_HELD: begin
                if (!btn_debounce) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        btn_held_d = (state_d == ST_LONG_HELD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_click_q <= 1'b0;
            btn_held_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            double_click_q <= double_click_d;
            btn_held_q     <= btn_held_d;
        end
    end

    assign short_press  = short_press_q;
    assign long_press   = long_press_q;
    assign double_click = double_click_q;
    assign btn_held     = btn_held_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with LONG_CYC=10 and DCLICK_CYC=5.
// Expected vectors are {short, long, double, held} after each sampled edge.
module tb_button_event_classifier;

    logic clk;
    logic reset;
    logic btn_debounce;
    logic short_press;
    logic long_press;
    logic double_click;
    logic btn_held;

    int checks;
    int errors;
    int step_no;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] SHRT = 4'b1000;
    localparam logic [3:0] LNGH = 4'b0101;
    localparam logic [3:0] DBL  = 4'b0010;
    localparam logic [3:0] HELD = 4'b0001;

    button_event_classifier #(
        .CLK_FREQ  (1000),
        .LONG_MS   (10),
        .DCLICK_MS (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_debounce (btn_debounce),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .btn_held     (btn_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_outs(input string tag, input logic [3:0] e);
        checks++;
        assert (short_press === e[3]) else begin
            errors++;
            $error("FAIL %s step %0d short_press got %b want %b", tag, step_no, short_press, e[3]);
        end
        checks++;
        assert (long_press === e[2]) else begin
            errors++;
            $error("FAIL %s step %0d long_press got %b want %b", tag, step_no, long_press, e[2]);
        end
        checks++;
        assert (double_click === e[1]) else begin
            errors++;
            $error("FAIL %s step %0d double_click got %b want %b", tag, step_no, double_click, e[1]);
        end
        checks++;
        assert (btn_held === e[0]) else begin
            errors++;
            $error("FAIL %s step %0d btn_held got %b want %b", tag, step_no, btn_held, e[0]);
        end
    endtask

    // Drive btn, let one rising edge sample it, then check the registered outputs.
    task automatic step(input string tag, input logic b, input logic [3:0] e);
        btn_debounce = b;
        @(posedge clk);
        #1;
        step_no++;
        check_outs(tag, e);
    endtask

    task automatic steps(input string tag, input int n, input logic b, input logic [3:0] e);
        for (int i = 0; i < n; i++) begin
            step(tag, b, e);
        end
    endtask

    task automatic do_reset(input string tag, input logic b, input int n);
        reset        = 1'b1;
        btn_debounce = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            step_no++;
            check_outs(tag, NONE);
        end
        reset = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        step_no      = 0;
        reset        = 1'b1;
        btn_debounce = 1'b0;
        #2;

        do_reset("reset", 1'b0, 2);
        steps("idle", 2, 1'b0, NONE);

        // Short press: 3 cycles held, short_press 5 edges after the release edge.
        steps("short_hold", 3, 1'b1, NONE);
        step("short_rel", 1'b0, NONE);
        steps("short_win", 4, 1'b0, NONE);
        step("short_evt", 1'b0, SHRT);
        steps("short_after", 5, 1'b0, NONE);

        // Long press: 15 cycles held, long_press 10 edges after the press edge.
        step("long_edge", 1'b1, NONE);
        steps("long_count", 9, 1'b1, NONE);
        step("long_evt", 1'b1, LNGH);
        steps("long_held", 4, 1'b1, HELD);
        step("long_rel", 1'b0, NONE);
        steps("long_after", 6, 1'b0, NONE);

        // Double click: 2 high, 2 low, then 20 high.
        steps("dbl_p1", 2, 1'b1, NONE);
        steps("dbl_gap", 2, 1'b0, NONE);
        step("dbl_evt", 1'b1, DBL);
        steps("dbl_p2", 19, 1'b1, NONE);
        step("dbl_rel", 1'b0, NONE);
        steps("dbl_after", 6, 1'b0, NONE);

        // Second press on the exact timeout edge: double_click wins.
        steps("edge_p1", 2, 1'b1, NONE);
        step("edge_rel", 1'b0, NONE);
        steps("edge_gap", 4, 1'b0, NONE);
        step("edge_evt", 1'b1, DBL);
        steps("edge_p2", 3, 1'b1, NONE);
        steps("edge_after", 7, 1'b0, NONE);

        // Held through reset: ignored until released and pressed again.
        do_reset("held_rst", 1'b1, 2);
        steps("held_ign", 12, 1'b1, NONE);
        steps("held_rel", 2, 1'b0, NONE);
        step("held_new", 1'b1, NONE);
        steps("held_count", 9, 1'b1, NONE);
        step("held_long", 1'b1, LNGH);
        step("held_done", 1'b0, NONE);
        steps("held_after", 3, 1'b0, NONE);

        // Reset 3 cycles into the double-click window aborts silently.
        steps("abort_p1", 2, 1'b1, NONE);
        step("abort_rel", 1'b0, NONE);
        steps("abort_win", 3, 1'b0, NONE);
        do_reset("abort_rst", 1'b0, 1);
        steps("abort_after", 8, 1'b0, NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_classifier.md
BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter LONG_MS, default 1000, press duration in ms that qualifies as a long press.
REQ-003 Parameter DCLICK_MS, default 300, maximum release gap in ms that still counts as a double click.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_debounce  input  1  debounced button level from the upstream 20 ms debouncer; already synchronous to clk.
REQ-007 short_press  output  1  one-cycle pulse: single press released before LONG, with no second press within DCLICK.
REQ-008 long_press  output  1  one-cycle pulse: press held continuously for LONG_CYC cycles.
REQ-009 double_click  output  1  one-cycle pulse: second press begins within DCLICK window after a short first press.
REQ-010 btn_held  output  1  level, high for as long as the FSM is in LONG_HELD.

Function
REQ-011 LONG_CYC SHALL be CLK_FREQ/1000*LONG_MS and DCLICK_CYC SHALL be CLK_FREQ/1000*DCLICK_MS, both at least 1.
REQ-012 A single counter of width $clog2(max(LONG_CYC,DCLICK_CYC)+1) SHALL serve both timing windows and SHALL never wrap.
REQ-013 A registered copy btn_prev SHALL detect rising edges; a press is btn_debounce=1 with btn_prev=0.
REQ-014 FSM states: IDLE, PRESS1, WAIT_SECOND, PRESS2, LONG_HELD.
REQ-015 IDLE: on a rising edge, go to PRESS1 with cnt=0; otherwise stay.
REQ-016 PRESS1, btn=1: if cnt==LONG_CYC-1, pulse long_press and go to LONG_HELD; else cnt+1.
REQ-017 PRESS1, btn=0: go to WAIT_SECOND with cnt=0.
REQ-018 WAIT_SECOND, btn=1: pulse double_click and go to PRESS2; this takes priority over timeout on the same edge.
REQ-019 WAIT_SECOND, btn=0: if cnt==DCLICK_CYC-1, pulse short_press and go to IDLE; else cnt+1.
REQ-020 PRESS2: wait for btn=0, then go to IDLE; a long hold here produces no event.
REQ-021 LONG_HELD: btn_held=1; on btn=0 go to IDLE; no repeat events.
REQ-022 Latency: long_press SHALL be high exactly LONG_CYC cycles after the edge that first samples the press.
REQ-023 Latency: short_press SHALL be high exactly DCLICK_CYC cycles after the edge that first samples the release.
REQ-024 Latency: double_click SHALL be high in the cycle after the edge that samples the second press.
REQ-025 All outputs SHALL be registered, and at most one event pulse SHALL be high in any cycle.

Reset
REQ-026 On reset: state=IDLE, cnt=0, and short_press, long_press, double_click, btn_held all 0.
REQ-027 btn_prev SHALL reset to 1, so a button held through reset is ignored until it is released and pressed again.
REQ-028 Reset asserted mid-press or mid-window SHALL abort the sequence with no event emitted.

Structure
REQ-029 Package btn_evt_pkg SHALL hold the FSM state enum typedef and a constant function ms_to_cycles(freq, ms).
REQ-030 Sub-module btn_edge_detect SHALL hold btn_prev and produce a rise pulse; it uses the same synchronous reset, resetting btn_prev to 1.

Verification (CLK_FREQ=1000, LONG_MS=10, DCLICK_MS=5, giving LONG_CYC=10 and DCLICK_CYC=5)
REQ-031 Press 3 cycles, release, idle 10 cycles -> short_press=1 exactly 5 cycles after the release edge; no other pulse.
REQ-032 Press held 15 cycles -> long_press pulse 10 cycles after the press edge; btn_held=1 until release; no short_press.
REQ-033 Press 2 cycles, release 2 cycles, press 20 cycles -> one double_click pulse 1 cycle after the second press edge; no long_press.
REQ-034 Second press sampled on the exact timeout edge (gap of 5 cycles) -> double_click only; short_press stays 0.
REQ-035 btn=1 during and after reset deassert -> no event until release followed by a new press.
REQ-036 Reset asserted 3 cycles into WAIT_SECOND -> all outputs 0 and no event pulse afterwards.
